// File: rtl/sliding_window_gen_if.sv
// Pixel-in / window-out bundle for sliding_window_gen.
// Latency: none, this is wiring only.
// Backpressure: in_ready gates pixel acceptance; the window side has no ready.
//
// Ports (signals):
//   pixel_valid, pixel_data  : raster pixel stream into the window generator
//   in_ready                 : pixel accepted when pixel_valid & in_ready
//   window_valid, window_data: one packed WINDOW_SIZE x WINDOW_SIZE neighbourhood
//   frame_done               : one-cycle pulse after the last pixel of a frame
// Modports: master = stream source / window sink, slave = the window generator.
interface sliding_window_gen_if #(
  parameter int WINDOW_SIZE = 3,
  parameter int PIXEL_WIDTH = 8
);
  logic                                           pixel_valid;
  logic [PIXEL_WIDTH-1:0]                         pixel_data;
  logic                                           in_ready;
  logic                                           window_valid;
  logic [WINDOW_SIZE*WINDOW_SIZE*PIXEL_WIDTH-1:0] window_data;
  logic                                           frame_done;

  modport master (
    output pixel_valid, pixel_data,
    input  in_ready, window_valid, window_data, frame_done
  );

  modport slave (
    input  pixel_valid, pixel_data,
    output in_ready, window_valid, window_data, frame_done
  );
endinterface

// File: rtl/sliding_window_gen.sv
// Raster pixel stream to WINDOW_SIZE x WINDOW_SIZE neighbourhoods for interior pixels.
// Latency: window_valid one cycle after accepting the pixel at the window's bottom-right.
// Backpressure: in_ready drops for exactly one cycle after each frame; no downstream ready.
//
// Ports:
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   win_if  : sliding_window_gen_if.slave (pixel stream in, windows and frame_done out)
// Tap (r,c) of window_data sits at [(r*WINDOW_SIZE+c)*PIXEL_WIDTH +: PIXEL_WIDTH];
// row 0 is the oldest line, column 0 the oldest pixel.
module sliding_window_gen #(
  parameter int WINDOW_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int PIXEL_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sliding_window_gen_if.slave  win_if
);

  localparam int W  = WINDOW_SIZE;
  localparam int DW = W * W * PIXEL_WIDTH;
  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN0 = CW'(W - 1);
  localparam logic [RW-1:0] ROW_WIN0 = RW'(W - 1);

  typedef enum logic {STREAM, FRAME_END} state_t;

  state_t                 state;
  logic [CW-1:0]          in_col;
  logic [RW-1:0]          in_row;
  logic                   in_ready_q;
  logic                   window_valid_q;
  logic                   frame_done_q;
  logic [DW-1:0]          window_data_q;

  // Line buffers: lb[0] is the oldest stored line, lb[W-2] the line just above the input.
  logic [PIXEL_WIDTH-1:0] lb      [W-1][IMAGE_WIDTH];
  logic [PIXEL_WIDTH-1:0] win     [W][W];
  logic [PIXEL_WIDTH-1:0] win_nxt [W][W];
  logic [DW-1:0]          win_packed;

  logic accept;
  logic emit;
  logic last_px;

  assign accept  = win_if.pixel_valid & in_ready_q;
  assign emit    = (in_row >= ROW_WIN0) && (in_col >= COL_WIN0);
  assign last_px = (in_row == ROW_LAST) && (in_col == COL_LAST);

  // Window after this accept: shift left, new right column is the buffered column plus input.
  always_comb begin
    win_nxt = win;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W - 1; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
    end
    for (int r = 0; r < W - 1; r++) begin
      win_nxt[r][W-1] = lb[r][in_col];
    end
    win_nxt[W-1][W-1] = win_if.pixel_data;
  end

  always_comb begin
    win_packed = '0;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        win_packed[(r*W+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = win_nxt[r][c];
      end
    end
  end

  // Line-buffer RAM carries no reset; stale contents only ever feed non-emitted windows.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < W - 2; k++) begin
        lb[k][in_col] <= lb[k+1][in_col];
      end
      lb[W-2][in_col] <= win_if.pixel_data;
    end
  end

  // The shift register advances on every accept, including the left-edge columns
  // whose windows are never emitted; it refills with the new row before emission.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < W; r++) begin
        for (int c = 0; c < W; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      win <= win_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= STREAM;
      in_col         <= '0;
      in_row         <= '0;
      in_ready_q     <= 1'b1;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      window_data_q  <= '0;
    end else begin
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      case (state)
        STREAM: begin
          if (accept) begin
            if (emit) begin
              window_valid_q <= 1'b1;
              window_data_q  <= win_packed;
            end
            if (last_px) begin
              in_col       <= '0;
              in_row       <= '0;
              state        <= FRAME_END;
              in_ready_q   <= 1'b0;
              frame_done_q <= 1'b1;
            end else if (in_col == COL_LAST) begin
              in_col <= '0;
              in_row <= in_row + 1'b1;
            end else begin
              in_col <= in_col + 1'b1;
            end
          end
        end
        FRAME_END: begin
          // One dead cycle: any pixel offered now stays with the source.
          state      <= STREAM;
          in_ready_q <= 1'b1;
        end
        default: begin
          state      <= STREAM;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign win_if.in_ready     = in_ready_q;
  assign win_if.window_valid = window_valid_q;
  assign win_if.window_data  = window_data_q;
  assign win_if.frame_done   = frame_done_q;

endmodule

// File: tb/tb_sliding_window_gen.sv
// Self-checking bench for sliding_window_gen (8x8 frames, W=3 main instance, W=5 side instance).
// Latency: checks every output one cycle after each accept against a frame-array reference.
// Backpressure: the source holds pixels through the dead cycle after each frame.
module tb_sliding_window_gen;

  localparam int W   = 3;
  localparam int W5  = 5;
  localparam int IW  = 8;
  localparam int IH  = 8;
  localparam int PW  = 8;
  localparam int DW  = W * W * PW;
  localparam int DW5 = W5 * W5 * PW;
  localparam int NT  = 10;

  logic          clk;
  logic          rst_n;
  logic          pv;
  logic [PW-1:0] pd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sliding_window_gen_if #(.WINDOW_SIZE(W),  .PIXEL_WIDTH(PW)) bus  ();
  sliding_window_gen_if #(.WINDOW_SIZE(W5), .PIXEL_WIDTH(PW)) bus5 ();

  assign bus.pixel_valid  = pv;
  assign bus.pixel_data   = pd;
  assign bus5.pixel_valid = pv;
  assign bus5.pixel_data  = pd;

  sliding_window_gen #(.WINDOW_SIZE(W), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .PIXEL_WIDTH(PW))
    dut (.clk(clk), .rst_n(rst_n), .win_if(bus.slave));

  sliding_window_gen #(.WINDOW_SIZE(W5), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .PIXEL_WIDTH(PW))
    dut5 (.clk(clk), .rst_n(rst_n), .win_if(bus5.slave));

  // ---------------- reference model: whole-frame array ----------------
  int            img [IH][IW];
  int            mr, mc;
  bit            m_rdy, exp_wv, exp_fd;
  logic [DW-1:0] exp_win;

  task automatic model_reset();
    mr = 0; mc = 0; m_rdy = 1'b1; exp_wv = 1'b0; exp_fd = 1'b0; exp_win = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        exp_wv = 1'b0;
        exp_fd = 1'b0;
        if (!m_rdy) begin
          m_rdy = 1'b1;
        end else if (pv) begin
          img[mr][mc] = int'(pd);
          if (mr >= W - 1 && mc >= W - 1) begin
            exp_wv = 1'b1;
            for (int i = 0; i < W; i++)
              for (int j = 0; j < W; j++)
                exp_win[(i*W+j)*PW +: PW] = PW'(img[mr-(W-1)+i][mc-(W-1)+j]);
          end
          mc++;
          if (mc == IW) begin
            mc = 0;
            mr++;
            if (mr == IH) begin
              mr = 0; m_rdy = 1'b0; exp_fd = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int             checks, errors;
  int             wv_cnt, wv5_cnt;
  bit             got5;
  logic [DW5-1:0] first5;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic int tap(input logic [DW-1:0] d, input int k);
    return int'(d[k*PW +: PW]);
  endfunction

  // Advance to the next falling edge and compare every W=3 output with the model.
  task automatic tick();
    @(negedge clk);
    checks++;
    if (bus.window_valid !== exp_wv || bus.frame_done !== exp_fd ||
        bus.in_ready !== m_rdy || bus.window_data !== exp_win) begin
      errors++;
      $display("FAIL cycle t=%0t: got vld=%b done=%b rdy=%b dat=%h, want vld=%b done=%b rdy=%b dat=%h",
               $time, bus.window_valid, bus.frame_done, bus.in_ready, bus.window_data,
               exp_wv, exp_fd, m_rdy, exp_win);
    end
    if (bus.window_valid) wv_cnt++;
    if (bus5.window_valid) begin
      wv5_cnt++;
      if (!got5) begin
        first5 = bus5.window_data;
        got5   = 1'b1;
      end
    end
  endtask

  // Offer one pixel; if the model says the block is in its dead cycle, hold it one more cycle.
  task automatic send(input int v);
    tick();
    pv = 1'b1;
    pd = PW'(v);
    if (!m_rdy) tick();
    @(posedge clk);
    #1 pv = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},     bus.in_ready,          1);
    chk({tag, "_window_valid"}, bus.window_valid,      0);
    chk({tag, "_window_data"},  (bus.window_data != 0), 0);
    chk({tag, "_frame_done"},   bus.frame_done,        0);
  endtask

  typedef struct {
    int row; int col;
    bit wv;  bit fd;  bit rdy;
    int t0;  int t4;  int t8;
  } vec_t;

  vec_t tbl [NT];

  // Contiguous frame of row*8+col, checked at the table positions plus window counts.
  task automatic run_table();
    int idx, c0, c5;
    idx = 0;
    c0  = wv_cnt;
    c5  = wv5_cnt;
    got5 = 1'b0;
    for (int e = 0; e < NT; e++) begin
      while (idx <= tbl[e].row * IW + tbl[e].col) begin
        send(idx);
        idx++;
      end
      tick();
      chk($sformatf("tbl%0d_vld", e),  bus.window_valid, tbl[e].wv);
      chk($sformatf("tbl%0d_done", e), bus.frame_done,   tbl[e].fd);
      chk($sformatf("tbl%0d_rdy", e),  bus.in_ready,     tbl[e].rdy);
      if (tbl[e].wv) begin
        chk($sformatf("tbl%0d_tap0", e), tap(bus.window_data, 0), tbl[e].t0);
        chk($sformatf("tbl%0d_tap4", e), tap(bus.window_data, 4), tbl[e].t4);
        chk($sformatf("tbl%0d_tap8", e), tap(bus.window_data, 8), tbl[e].t8);
      end
    end
    tick();
    tick();
    chk("frame_windows_w3", wv_cnt - c0, 36);
    chk("frame_windows_w5", wv5_cnt - c5, 16);
    chk("w5_seen", got5, 1);
    for (int r = 0; r < W5; r++)
      for (int c = 0; c < W5; c++)
        chk($sformatf("w5_first_tap_r%0d_c%0d", r, c),
            int'(first5[(r*W5+c)*PW +: PW]), r * IW + c);
  endtask

  task automatic gap_frame(input bit random_pix);
    int c0;
    c0 = wv_cnt;
    for (int i = 0; i < IW * IH; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(random_pix ? int'($urandom_range(0, 255)) : i);
    end
    tick();
    tick();
    chk(random_pix ? "gap_rand_windows" : "gap_windows", wv_cnt - c0, 36);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 0, 0, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 7, 0, 0, 1, 0, 0, 0};
    tbl[2] = '{2, 0, 0, 0, 1, 0, 0, 0};
    tbl[3] = '{2, 1, 0, 0, 1, 0, 0, 0};
    tbl[4] = '{2, 2, 1, 0, 1, 0, 9, 18};
    tbl[5] = '{2, 7, 1, 0, 1, 5, 14, 23};
    tbl[6] = '{3, 1, 0, 0, 1, 0, 0, 0};
    tbl[7] = '{3, 2, 1, 0, 1, 8, 17, 26};
    tbl[8] = '{5, 4, 1, 0, 1, 26, 35, 44};
    tbl[9] = '{7, 7, 1, 1, 0, 45, 54, 63};

    checks = 0; errors = 0; wv_cnt = 0; wv5_cnt = 0; got5 = 1'b0; first5 = '0;
    pv = 1'b0; pd = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Contiguous frame with row-boundary and frame-end positions.
    run_table();

    // Random gaps with the canonical values, then random values.
    gap_frame(1'b0);
    gap_frame(1'b1);

    // Frame end with a held valid, then a back-to-back +100 frame.
    for (int i = 0; i < IW * IH; i++) send(i);
    tick();
    chk("fe_done", bus.frame_done, 1);
    chk("fe_rdy",  bus.in_ready,   0);
    pv = 1'b1;
    pd = PW'(100);
    for (int i = 0; i < IW * IH; i++) begin
      send(100 + i);
      if (i == 2 * IW + 2) begin
        tick();
        chk("f2_vld", bus.window_valid, 1);
        for (int k = 0; k < W * W; k++)
          chk($sformatf("f2_tap%0d", k), tap(bus.window_data, k), 100 + (k / W) * IW + (k % W));
      end
    end
    tick();

    // Reset mid-frame right after a window pulse, then a clean frame.
    for (int i = 0; i <= 30; i++) send(i);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    tick();
    rst_n = 1'b1;
    run_table();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
